// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind the UART core.
// Each flagged frame is captured once, acknowledged with a one-cycle
// rx_flag_clr pulse, and stored in a first-word-fall-through FIFO.
// Optional build macro: UART_RX_FIFO_PERR_DROP_EN. When it is defined,
// frames with a parity error are acknowledged but discarded and counted
// on perr_drop_cnt, and rd_perr reads as 0.
module uart_rx_fifo #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       rx_flag,
    input  logic [UART_DATA_WIDTH-1:0] rx_data,
    input  logic                       parity_error,
    output logic                       rx_flag_clr,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [UART_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_perr,
    output logic [FIFO_AW:0]           fifo_count,
    output logic                       fifo_full,
    output logic                       overflow,
    input  logic                       overflow_clr
`ifdef UART_RX_FIFO_PERR_DROP_EN
    ,
    output logic [7:0]                 perr_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } cap_state_e;

`ifdef UART_RX_FIFO_PERR_DROP_EN
    localparam int ENTRY_W = UART_DATA_WIDTH;
`else
    localparam int ENTRY_W = UART_DATA_WIDTH + 1;
`endif

    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW + 1)'(0);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(0);

    cap_state_e         state_r;
    logic               rx_flag_clr_r;
    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               rd_valid_r;
    logic               full_r;
    logic               overflow_r;

    logic               capture_s;
    logic               store_s;
    logic               pop_s;
    logic               push_ok_s;
    logic               drop_ovf_s;
    logic [FIFO_AW:0]   count_nxt_s;
    logic [ENTRY_W-1:0] entry_s;

    // Decide capture, push acceptance, pop and overflow for this cycle.
    always_comb begin
        capture_s  = 1'b0;
        store_s    = 1'b0;
        pop_s      = 1'b0;
        push_ok_s  = 1'b0;
        drop_ovf_s = 1'b0;
        if ((state_r == ST_IDLE) && rx_flag) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
`ifdef UART_RX_FIFO_PERR_DROP_EN
        store_s = capture_s & ~parity_error;
`else
        store_s = capture_s;
`endif
        pop_s = rd_valid_r & rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (store_s && (!full_r || pop_s)) begin
            push_ok_s  = 1'b1;
            drop_ovf_s = 1'b0;
        end else if (store_s) begin
            push_ok_s  = 1'b0;
            drop_ovf_s = 1'b1;
        end else begin
            push_ok_s  = 1'b0;
            drop_ovf_s = 1'b0;
        end
    end

    // Next fill level from the push/pop combination.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Build the stored entry: parity tag above the data byte when it is kept.
    always_comb begin
`ifdef UART_RX_FIFO_PERR_DROP_EN
        entry_s = rx_data;
`else
        entry_s = {parity_error, rx_data};
`endif
    end

    // Capture handshake FSM with registered acknowledge pulse.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            rx_flag_clr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_flag) begin
                        state_r       <= ST_ACK;
                        rx_flag_clr_r <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                        rx_flag_clr_r <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_r       <= ST_WAIT;
                    rx_flag_clr_r <= 1'b0;
                end
                ST_WAIT: begin
                    rx_flag_clr_r <= 1'b0;
                    if (!rx_flag) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    rx_flag_clr_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (n_rst && push_ok_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers, fill level and the status flags derived from it.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            rd_valid_r <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            rd_valid_r <= (count_nxt_s != CNT_ZERO);
            full_r     <= (count_nxt_s == DEPTH_C);
        end
    end

    // Sticky overflow: a dropped frame outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            overflow_r <= 1'b0;
        end else if (drop_ovf_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_PERR_DROP_EN
    logic [7:0] perr_drop_cnt_r;

    // Saturating count of frames discarded for parity errors.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            perr_drop_cnt_r <= 8'd0;
        end else if (capture_s && parity_error && (perr_drop_cnt_r != 8'hFF)) begin
            perr_drop_cnt_r <= perr_drop_cnt_r + 8'd1;
        end
    end

    assign perr_drop_cnt = perr_drop_cnt_r;
    assign rd_data       = mem_r[rd_ptr_r];
    assign rd_perr       = 1'b0;
`else
    assign rd_data = mem_r[rd_ptr_r][UART_DATA_WIDTH-1:0];
    assign rd_perr = mem_r[rd_ptr_r][UART_DATA_WIDTH];
`endif

    assign rx_flag_clr = rx_flag_clr_r;
    assign rd_valid    = rd_valid_r;
    assign fifo_count  = count_r;
    assign fifo_full   = full_r;
    assign overflow    = overflow_r;

endmodule
